// File: rtl/noc_packet_consumer.sv
// NoC receive-side unpacker: flits (hdr/body/tail/headtail) to a 1-byte AXI Stream with TID/TDEST/TLAST.
// Optional protocol checking enabled by defining NOC_PACKET_CONSUMER_PROTO_CHECK_EN.
module noc_packet_consumer #(
    parameter int unsigned NocDataWidth             = 64,
    parameter int unsigned flitTypeSize             = 2,
    parameter int unsigned NocVirtualChannelIdWidth = 3,
    parameter int unsigned TIdWidth                 = 8,
    parameter int unsigned TDestWidth               = 11
) (
    input  logic                                clk_noc,
    input  logic                                rst_noc,
    input  logic [NocDataWidth-1:0]             network_flit_i,
    input  logic [flitTypeSize-1:0]             network_flit_type_i,
    input  logic [NocVirtualChannelIdWidth-1:0] network_vc_i,
    input  logic                                network_valid_i,
    output logic                                network_ready_o,
    output logic [7:0]                          m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [TIdWidth-1:0]                 m_axis_tid,
    output logic [TDestWidth-1:0]               m_axis_tdest,
    output logic                                proto_error_o
);

    localparam logic [1:0] FtHdr  = 2'b00;
    localparam logic [1:0] FtBody = 2'b01;
    localparam logic [1:0] FtTail = 2'b10;
    localparam logic [1:0] FtHt   = 2'b11;

    typedef enum logic [0:0] {ST_IDLE, ST_OPEN} state_e;

    state_e                    state_q, state_d;
    logic [NocDataWidth-1:0]   fbuf_q, fbuf_d;
    logic [flitTypeSize-1:0]   ftype_q, ftype_d;
    logic                      fbuf_valid_q, fbuf_valid_d;
    logic [2:0]                idx_q, idx_d;
    logic [7:0]                hold_q, hold_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [TIdWidth-1:0]       tid_lat_q, tid_lat_d;
    logic [TDestWidth-1:0]     tdest_lat_q, tdest_lat_d;
    logic                      ready_q, ready_d;
    logic                      tvalid_q, tvalid_d;
    logic [7:0]                tdata_q, tdata_d;
    logic                      tlast_q, tlast_d;
    logic [TIdWidth-1:0]       tid_q, tid_d;
    logic [TDestWidth-1:0]     tdest_q, tdest_d;
    logic                      err_q, err_d;

    logic                      is_hdr_c, is_body_c, is_tail_c, is_ht_c, is_start_c, holds_c;
    logic [6:0]                pad_c;
    logic [3:0]                n_c;
    logic [3:0]                idx_ext_c;
    logic                      pad_ok_c, last_bit_c, bad_c, load_ok_c, flit_done_c;
    logic [7:0]                byte_c [8];
    logic                      beat_c, beat_last_c;
    logic [7:0]                beat_data_c;
    logic [TIdWidth-1:0]       beat_tid_c;
    logic [TDestWidth-1:0]     beat_tdest_c;
    logic                      unused_c;

    assign unused_c = ^{network_vc_i, pad_ok_c, last_bit_c};

    // Decode of the buffered flit: type, valid byte count, pad contiguity
    always_comb begin
        is_hdr_c   = (ftype_q == FtHdr);
        is_body_c  = (ftype_q == FtBody);
        is_tail_c  = (ftype_q == FtTail);
        is_ht_c    = (ftype_q == FtHt);
        is_start_c = is_hdr_c || is_ht_c;
        holds_c    = is_hdr_c || is_body_c;
        for (int i = 0; i < 8; i++) begin
            byte_c[i] = fbuf_q[8*i +: 8];
        end
        if (is_start_c) begin
            pad_c = {3'b111, fbuf_q[35:32]};
        end else if (is_tail_c) begin
            pad_c = fbuf_q[62:56];
        end else begin
            pad_c = 7'h00;
        end
        last_bit_c = is_start_c ? fbuf_q[36] : fbuf_q[63];
        n_c = 4'd7;
        for (int i = 6; i >= 0; i--) begin
            if (pad_c[i]) begin
                n_c = 4'(i);
            end
        end
        if (is_body_c) begin
            n_c = 4'd8;
        end
        pad_ok_c  = (pad_c == (7'h7F << n_c));
        idx_ext_c = {1'b0, idx_q};
`ifdef NOC_PACKET_CONSUMER_PROTO_CHECK_EN
        bad_c = ((is_body_c || is_tail_c) && (state_q == ST_IDLE)) || !pad_ok_c
              || (is_start_c && (n_c == 4'd0)) || (is_tail_c && !last_bit_c);
`else
        bad_c = 1'b0;
`endif
    end

    assign load_ok_c = !tvalid_q || m_axis_tready;

    // Packet FSM, holdback register and beat selection
    always_comb begin
        state_d      = state_q;
        fbuf_d       = fbuf_q;
        ftype_d      = ftype_q;
        fbuf_valid_d = fbuf_valid_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tid_lat_d    = tid_lat_q;
        tdest_lat_d  = tdest_lat_q;
        err_d        = err_q;
        flit_done_c  = 1'b0;
        beat_c       = 1'b0;
        beat_data_c  = 8'h00;
        beat_last_c  = 1'b0;
        beat_tid_c   = tid_lat_q;
        beat_tdest_c = tdest_lat_q;

        if (fbuf_valid_q) begin
            if (bad_c) begin
                fbuf_valid_d = 1'b0;
                idx_d        = 3'd0;
                err_d        = 1'b1;
            end else if (is_start_c && hold_valid_q) begin
                // Header arrived while a packet is open: close it with the held byte
`ifdef NOC_PACKET_CONSUMER_PROTO_CHECK_EN
                err_d = 1'b1;
`endif
                if (load_ok_c) begin
                    beat_c       = 1'b1;
                    beat_data_c  = hold_q;
                    beat_last_c  = 1'b1;
                    hold_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end else if (hold_valid_q) begin
                if (load_ok_c) begin
                    beat_c       = 1'b1;
                    beat_data_c  = hold_q;
                    beat_last_c  = is_tail_c && (n_c == 4'd0);
                    hold_valid_d = 1'b0;
                    flit_done_c  = beat_last_c;
                end
            end else if (n_c == 4'd0) begin
                flit_done_c = 1'b1;
            end else if (holds_c && (idx_ext_c == n_c - 4'd1)) begin
                hold_d       = byte_c[idx_q];
                hold_valid_d = 1'b1;
                flit_done_c  = 1'b1;
            end else if (load_ok_c) begin
                beat_c      = 1'b1;
                beat_data_c = byte_c[idx_q];
                beat_last_c = !holds_c && (idx_ext_c == n_c - 4'd1);
                if (is_start_c) begin
                    beat_tid_c   = fbuf_q[37 +: TIdWidth];
                    beat_tdest_c = fbuf_q[45 +: TDestWidth];
                end
                if (holds_c && (idx_ext_c == n_c - 4'd2)) begin
                    hold_d       = byte_c[idx_q + 3'd1];
                    hold_valid_d = 1'b1;
                    flit_done_c  = 1'b1;
                end else if (beat_last_c) begin
                    flit_done_c = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            if (flit_done_c) begin
                fbuf_valid_d = 1'b0;
                idx_d        = 3'd0;
                state_d      = holds_c ? ST_OPEN : ST_IDLE;
                if (is_start_c) begin
                    tid_lat_d   = fbuf_q[37 +: TIdWidth];
                    tdest_lat_d = fbuf_q[45 +: TDestWidth];
                end
            end
        end else if (network_valid_i && ready_q) begin
            fbuf_d       = network_flit_i;
            ftype_d      = network_flit_type_i;
            fbuf_valid_d = 1'b1;
            idx_d        = 3'd0;
        end
    end

    // AXI Stream output stage
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        ready_d  = !fbuf_valid_d;
        if (load_ok_c) begin
            tvalid_d = beat_c;
            if (beat_c) begin
                tdata_d = beat_data_c;
                tlast_d = beat_last_c;
                tid_d   = beat_tid_c;
                tdest_d = beat_tdest_c;
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            state_q      <= ST_IDLE;
            fbuf_q       <= '0;
            ftype_q      <= '0;
            fbuf_valid_q <= 1'b0;
            idx_q        <= 3'd0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            tid_lat_q    <= '0;
            tdest_lat_q  <= '0;
            ready_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= 8'h00;
            tlast_q      <= 1'b0;
            tid_q        <= '0;
            tdest_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fbuf_q       <= fbuf_d;
            ftype_q      <= ftype_d;
            fbuf_valid_q <= fbuf_valid_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tid_lat_q    <= tid_lat_d;
            tdest_lat_q  <= tdest_lat_d;
            ready_q      <= ready_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tid_q        <= tid_d;
            tdest_q      <= tdest_d;
            err_q        <= err_d;
        end
    end

    assign network_ready_o = ready_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tdata    = tdata_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tid      = tid_q;
    assign m_axis_tdest    = tdest_q;
    assign proto_error_o   = err_q;

endmodule

// File: tb/tb_noc_packet_consumer.sv
// Directed bench for noc_packet_consumer: hand-built flits, expected beats listed per case.
module tb_noc_packet_consumer;

    localparam logic [1:0] FtHdr  = 2'b00;
    localparam logic [1:0] FtBody = 2'b01;
    localparam logic [1:0] FtTail = 2'b10;
    localparam logic [1:0] FtHt   = 2'b11;

    logic        clk_noc = 1'b0;
    logic        rst_noc;
    logic [63:0] network_flit_i;
    logic [1:0]  network_flit_type_i;
    logic [2:0]  network_vc_i;
    logic        network_valid_i;
    logic        network_ready_o;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [10:0] m_axis_tdest;
    logic        proto_error_o;

    int          n_checks = 0;
    int          n_pass = 0;
    int          stall_mode = 0;
    logic        stall_prev = 1'b0;
    logic [28:0] prev_beat = '0;
    logic [27:0] beat_q [$];
    logic [27:0] exp_q [$];

    always #5 clk_noc = ~clk_noc;

    noc_packet_consumer dut (
        .clk_noc             (clk_noc),
        .rst_noc             (rst_noc),
        .network_flit_i      (network_flit_i),
        .network_flit_type_i (network_flit_type_i),
        .network_vc_i        (network_vc_i),
        .network_valid_i     (network_valid_i),
        .network_ready_o     (network_ready_o),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tid          (m_axis_tid),
        .m_axis_tdest        (m_axis_tdest),
        .proto_error_o       (proto_error_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Sink side: drive tready, verify stall stability, record accepted beats
    always @(negedge clk_noc) begin
        logic [28:0] cur;
        m_axis_tready = (stall_mode != 0) ? ~m_axis_tready : 1'b1;
        cur = {m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tdata};
        if (stall_prev) check("stall_stable", 64'(cur), 64'(prev_beat));
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_beat  = cur;
        if (m_axis_tvalid && m_axis_tready) beat_q.push_back(cur[27:0]);
    end

    function automatic logic [63:0] mk_hdr(input logic [31:0] d, input logic [3:0] pad,
                                           input logic last, input logic [7:0] tid,
                                           input logic [10:0] src);
        logic [63:0] f;
        f = '0;
        f[31:0]  = d;
        f[35:32] = pad;
        f[36]    = last;
        f[44:37] = tid;
        f[55:45] = src;
        return f;
    endfunction

    function automatic logic [63:0] mk_tail(input logic [55:0] d, input logic [6:0] pad,
                                            input logic last);
        return {last, pad, d};
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic last, input logic [7:0] tid,
                            input logic [10:0] src);
        exp_q.push_back({last, tid, src, d});
    endtask

    // Called at a negedge; returns at the negedge after the flit was taken
    task automatic send_flit(input logic [63:0] f, input logic [1:0] t);
        int waited;
        waited = 0;
        network_flit_i      = f;
        network_flit_type_i = t;
        network_valid_i     = 1'b1;
        while (!network_ready_o && waited < 200) begin
            @(negedge clk_noc);
            waited++;
        end
        if (waited >= 200) check("accept_timeout", 64'd1, 64'd0);
        @(negedge clk_noc);
        network_valid_i = 1'b0;
        check("ready_low_after_accept", 64'(network_ready_o), 64'd0);
    endtask

    task automatic drain_and_compare(input string tag);
        int waited;
        waited = 0;
        while (beat_q.size() < exp_q.size() && waited < 400) begin
            @(negedge clk_noc);
            waited++;
        end
        repeat (10) @(negedge clk_noc);
        check({tag, "_count"}, 64'(beat_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < beat_q.size()) check($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]), 64'(exp_q[i]));
            else check($sformatf("%s_beat%0d_missing", tag, i), 64'hDEAD_BEEF, 64'(exp_q[i]));
        end
        beat_q.delete();
        exp_q.delete();
    endtask

    task automatic run_short(input logic [7:0] tid, input logic [10:0] src);
        send_flit(mk_hdr(32'h0000_BBAA, 4'b1100, 1'b1, tid, src), FtHt);
        push_exp(8'hAA, 1'b0, tid, src);
        push_exp(8'hBB, 1'b1, tid, src);
    endtask

    task automatic run_long(input logic [7:0] tid, input logic [10:0] src, input logic empty_tail);
        send_flit(mk_hdr(32'h0302_0100, 4'b0000, 1'b0, tid, src), FtHdr);
        send_flit(64'h0B0A_0908_0706_0504, FtBody);
        if (empty_tail) begin
            send_flit(mk_tail(56'h0, 7'h7F, 1'b1), FtTail);
            for (int i = 0; i < 12; i++) push_exp(8'(i), i == 11, tid, src);
        end else begin
            send_flit(mk_tail(56'h0E_0D0C, 7'h78, 1'b1), FtTail);
            for (int i = 0; i < 15; i++) push_exp(8'(i), i == 14, tid, src);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_noc             = 1'b1;
        network_flit_i      = '0;
        network_flit_type_i = FtHdr;
        network_vc_i        = 3'd0;
        network_valid_i     = 1'b0;
        repeat (3) @(negedge clk_noc);
        check("reset_outputs",
              64'({network_ready_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                   m_axis_tid, m_axis_tdest, proto_error_o}), 64'd0);
        rst_noc = 1'b0;
        @(negedge clk_noc);
        check("ready_after_reset", 64'(network_ready_o), 64'd1);

        run_short(8'h05, 11'h003);
        drain_and_compare("headtail");

        run_long(8'h21, 11'h155, 1'b0);
        drain_and_compare("hdr_body_tail");

        run_long(8'h3C, 11'h2A5, 1'b1);
        drain_and_compare("empty_tail");

        stall_mode = 1;
        run_long(8'h47, 11'h7FF, 1'b0);
        drain_and_compare("stalled");
        stall_mode = 0;
        repeat (2) @(negedge clk_noc);

        // Reset in the middle of a body flit, then a clean short packet
        send_flit(mk_hdr(32'h0302_0100, 4'b0000, 1'b0, 8'h11, 11'h011), FtHdr);
        send_flit(64'h0B0A_0908_0706_0504, FtBody);
        rst_noc = 1'b1;
        @(negedge clk_noc);
        check("midpkt_reset_outputs",
              64'({network_ready_o, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                   m_axis_tid, m_axis_tdest, proto_error_o}), 64'd0);
        rst_noc = 1'b0;
        @(negedge clk_noc);
        check("ready_after_midpkt_reset", 64'(network_ready_o), 64'd1);
        beat_q.delete();
        run_short(8'h5A, 11'h1A5);
        drain_and_compare("post_reset");

        // Body flit with no open packet
        send_flit(64'h1716_1514_1312_1110, FtBody);
        repeat (20) @(negedge clk_noc);
`ifdef NOC_PACKET_CONSUMER_PROTO_CHECK_EN
        check("proto_err_set", 64'(proto_error_o), 64'd1);
        check("proto_drop_beats", 64'(beat_q.size()), 64'd0);
        repeat (10) @(negedge clk_noc);
        check("proto_err_sticky", 64'(proto_error_o), 64'd1);
`else
        check("proto_err_off", 64'(proto_error_o), 64'd0);
        repeat (10) @(negedge clk_noc);
        check("proto_err_off_later", 64'(proto_error_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
